// File: rtl/adc_spi_responder.sv
// ADC-side responder: turns a Read/Channel_Select request into SPI mode-3 frames to an 8-channel 12-bit ADC.
// Optional build macro ADC_SPI_AVG4_EN: four real frames per request, rounded average returned.
module adc_spi_responder #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        Read,
    input  logic [3:0]  Channel_Select,
    output logic [11:0] Resault,
    output logic        RDY_BSYn,
    output logic        ADC_CS_n,
    output logic        ADC_SCLK,
    output logic        ADC_DIN,
    input  logic        ADC_DOUT
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);

    state_t      state_q, state_d;
    logic [2:0]  ch_q, ch_d;
    logic [2:0]  last_ch_q, last_ch_d;
    logic        last_ch_valid_q, last_ch_valid_d;
    logic        dummy_q, dummy_d;
    logic [3:0]  setup_cnt_q, setup_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] shift_q, shift_d;
    logic [11:0] resault_q, resault_d;
    logic        rdy_q, rdy_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        din_q, din_d;
    logic [15:0] frame_w;
    logic [3:0]  next_bit;
`ifdef ADC_SPI_AVG4_EN
    logic [13:0] acc_q, acc_d;
    logic [13:0] acc_sum;
    logic [13:0] acc_round;
    logic [1:0]  real_cnt_q, real_cnt_d;
`endif

    assign Resault  = resault_q;
    assign RDY_BSYn = rdy_q;
    assign ADC_CS_n = cs_n_q;
    assign ADC_SCLK = sclk_q;
    assign ADC_DIN  = din_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q         <= IDLE;
            ch_q            <= '0;
            last_ch_q       <= '0;
            last_ch_valid_q <= 1'b0;
            dummy_q         <= 1'b0;
            setup_cnt_q     <= '0;
            div_cnt_q       <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            resault_q       <= '0;
            rdy_q           <= 1'b0;
            cs_n_q          <= 1'b1;
            sclk_q          <= 1'b1;
            din_q           <= 1'b0;
`ifdef ADC_SPI_AVG4_EN
            acc_q           <= '0;
            real_cnt_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            ch_q            <= ch_d;
            last_ch_q       <= last_ch_d;
            last_ch_valid_q <= last_ch_valid_d;
            dummy_q         <= dummy_d;
            setup_cnt_q     <= setup_cnt_d;
            div_cnt_q       <= div_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            resault_q       <= resault_d;
            rdy_q           <= rdy_d;
            cs_n_q          <= cs_n_d;
            sclk_q          <= sclk_d;
            din_q           <= din_d;
`ifdef ADC_SPI_AVG4_EN
            acc_q           <= acc_d;
            real_cnt_q      <= real_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d         = state_q;
        ch_d            = ch_q;
        last_ch_d       = last_ch_q;
        last_ch_valid_d = last_ch_valid_q;
        dummy_d         = dummy_q;
        setup_cnt_d     = setup_cnt_q;
        div_cnt_d       = div_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        resault_d       = resault_q;
        rdy_d           = rdy_q;
        cs_n_d          = cs_n_q;
        sclk_d          = sclk_q;
        din_d           = din_q;
        frame_w         = {2'b00, ch_q, 11'b0};
        next_bit        = bit_cnt_q - 4'd1;
`ifdef ADC_SPI_AVG4_EN
        acc_d           = acc_q;
        real_cnt_d      = real_cnt_q;
        acc_sum         = acc_q + {2'b00, shift_q};
        acc_round       = acc_sum + 14'd2;
`endif

        case (state_q)
            IDLE: begin
                rdy_d = 1'b0;
                if (Read) begin
                    ch_d = Channel_Select[2:0];
                    if (Channel_Select[3]) begin
                        resault_d = '0;
                        rdy_d     = 1'b1;
                        state_d   = DONE;
                    end else begin
                        // The ADC answers with the previous frame's channel, so a new channel needs a priming frame.
                        dummy_d     = !(last_ch_valid_q && (last_ch_q == Channel_Select[2:0]));
                        cs_n_d      = 1'b0;
                        setup_cnt_d = '0;
                        state_d     = SETUP;
`ifdef ADC_SPI_AVG4_EN
                        acc_d       = '0;
                        real_cnt_d  = '0;
`endif
                    end
                end
            end
            SETUP: begin
                if (setup_cnt_q == SETUP_LAST) begin
                    sclk_d    = 1'b0;
                    din_d     = frame_w[15];
                    bit_cnt_d = 4'd15;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    setup_cnt_d = setup_cnt_q + 4'd1;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        // Only the last 12 of the 16 sampled bits carry data; earlier ones fall off the top.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[10:0], ADC_DOUT};
                    end else if (bit_cnt_q == 4'd0) begin
                        cs_n_d  = 1'b1;
                        din_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = next_bit;
                        sclk_d    = 1'b0;
                        din_d     = frame_w[next_bit];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                last_ch_d       = ch_q;
                last_ch_valid_d = 1'b1;
                setup_cnt_d     = '0;
                if (dummy_q) begin
                    dummy_d = 1'b0;
                    cs_n_d  = 1'b0;
                    state_d = SETUP;
                end else begin
`ifdef ADC_SPI_AVG4_EN
                    if (real_cnt_q == 2'd3) begin
                        resault_d = acc_round[13:2];
                        rdy_d     = 1'b1;
                        state_d   = DONE;
                    end else begin
                        acc_d      = acc_sum;
                        real_cnt_d = real_cnt_q + 2'd1;
                        cs_n_d     = 1'b0;
                        state_d    = SETUP;
                    end
`else
                    resault_d = shift_q;
                    rdy_d     = 1'b1;
                    state_d   = DONE;
`endif
                end
            end
            DONE: begin
                if (!Read) begin
                    rdy_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder with a pipelined SPI mode-3 ADC model and a result scoreboard.
`timescale 1ns/1ps
module tb_adc_spi_responder;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int WIN      = CS_SETUP + 32 * CLK_DIV;
    localparam int BUDGET   = 3000;
`ifdef ADC_SPI_AVG4_EN
    localparam int REAL_FRAMES = 4;
`else
    localparam int REAL_FRAMES = 1;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        Read = 1'b0;
    logic [3:0]  Channel_Select = 4'd0;
    logic [11:0] Resault;
    logic        RDY_BSYn;
    logic        ADC_CS_n;
    logic        ADC_SCLK;
    logic        ADC_DIN;
    logic        ADC_DOUT = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 HCLK = ~HCLK;

    adc_spi_responder #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .Read(Read), .Channel_Select(Channel_Select),
        .Resault(Resault), .RDY_BSYn(RDY_BSYn), .ADC_CS_n(ADC_CS_n),
        .ADC_SCLK(ADC_SCLK), .ADC_DIN(ADC_DIN), .ADC_DOUT(ADC_DOUT)
    );

    // ADC model: returns the channel addressed in the previous complete frame.
    logic [11:0] adc_data [8];
    logic [11:0] ovr_q [$];
    logic [15:0] din_q [$];
    int          win_q [$];
    logic [11:0] exp_q [$];
    logic [15:0] tx_sr = 16'h0;
    logic [15:0] rx_sr = 16'h0;
    int          rx_bits = 0;
    logic [2:0]  prev_ch = 3'd0;
    int          low_cnt = 0;

    always @(negedge ADC_CS_n) begin
        if (ovr_q.size() > 0) tx_sr = {4'h0, ovr_q.pop_front()};
        else                  tx_sr = {4'h0, adc_data[prev_ch]};
        rx_bits = 0;
    end

    always @(negedge ADC_SCLK) begin
        if (ADC_CS_n === 1'b0) begin
            ADC_DOUT = tx_sr[15];
            tx_sr    = {tx_sr[14:0], 1'b0};
        end
    end

    always @(posedge ADC_SCLK) begin
        if (ADC_CS_n === 1'b0) begin
            rx_sr   = {rx_sr[14:0], ADC_DIN};
            rx_bits = rx_bits + 1;
        end
    end

    always @(posedge ADC_CS_n) begin
        if (rx_bits == 16) begin
            prev_ch = rx_sr[13:11];
            din_q.push_back(rx_sr);
        end
        rx_bits = 0;
    end

    always @(negedge HCLK) begin
        if (ADC_CS_n === 1'b0) low_cnt = low_cnt + 1;
        else if (low_cnt != 0) begin
            win_q.push_back(low_cnt);
            low_cnt = 0;
        end
    end

    task automatic run_request(input logic [3:0] ch, output int cycles, output bit timed_out);
        @(negedge HCLK);
        Read = 1'b1;
        Channel_Select = ch;
        cycles = 0;
        timed_out = 1'b1;
        while (cycles < BUDGET) begin
            @(negedge HCLK);
            cycles++;
            if (RDY_BSYn === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge HCLK);
        checks++; if (Resault !== 12'h000) begin errors++; $display("FAIL reset_resault: got %h want 000", Resault); end
        checks++; if (RDY_BSYn !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", RDY_BSYn); end
        checks++; if (ADC_CS_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", ADC_CS_n); end
        checks++; if (ADC_SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", ADC_SCLK); end
        checks++; if (ADC_DIN !== 1'b0) begin errors++; $display("FAIL reset_din: got %b want 0", ADC_DIN); end
        HRESET = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_new_channel();
        int cyc; bit to; logic [11:0] exp; int nwin;
        adc_data[3] = 12'hA5C;
        win_q.delete(); din_q.delete();
        exp_q.push_back(12'hA5C);
        run_request(4'd3, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL new_ch_timeout: no RDY_BSYn after %0d cycles", cyc); end
        exp = exp_q.pop_front();
        checks++; if (Resault !== exp) begin errors++; $display("FAIL new_ch_result: got %h want %h", Resault, exp); end
        checks++; if (cyc != (1 + REAL_FRAMES) * (WIN + 1) + 1) begin errors++; $display("FAIL new_ch_latency: got %0d want %0d", cyc, (1 + REAL_FRAMES) * (WIN + 1) + 1); end
        checks++; if (win_q.size() != 1 + REAL_FRAMES) begin errors++; $display("FAIL new_ch_frames: got %0d want %0d", win_q.size(), 1 + REAL_FRAMES); end
        foreach (win_q[i]) begin
            checks++; if (win_q[i] != WIN) begin errors++; $display("FAIL new_ch_window%0d: got %0d want %0d", i, win_q[i], WIN); end
        end
        foreach (din_q[i]) begin
            checks++; if (din_q[i] !== {2'b00, 3'd3, 11'd0}) begin errors++; $display("FAIL new_ch_din%0d: got %h want %h", i, din_q[i], {2'b00, 3'd3, 11'd0}); end
        end
        nwin = win_q.size();
        repeat (4) @(negedge HCLK);
        checks++; if (RDY_BSYn !== 1'b1 || win_q.size() != nwin || ADC_CS_n !== 1'b1) begin errors++; $display("FAIL held_read: rdy=%b cs_n=%b frames=%0d want rdy=1 cs_n=1 frames=%0d", RDY_BSYn, ADC_CS_n, win_q.size(), nwin); end
        Read = 1'b0;
        @(negedge HCLK);
        checks++; if (RDY_BSYn !== 1'b0) begin errors++; $display("FAIL rdy_drop: got %b want 0", RDY_BSYn); end
        $display("new channel 3: result %h in %0d cycles, %0d frames", exp, cyc, nwin);
    endtask

    task automatic test_repeat_channel();
        int cyc; bit to; logic [11:0] exp;
        adc_data[3] = 12'h123;
        win_q.delete(); din_q.delete();
        exp_q.push_back(12'h123);
        run_request(4'd3, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL repeat_timeout: no RDY_BSYn after %0d cycles", cyc); end
        exp = exp_q.pop_front();
        checks++; if (Resault !== exp) begin errors++; $display("FAIL repeat_result: got %h want %h", Resault, exp); end
        checks++; if (win_q.size() != REAL_FRAMES) begin errors++; $display("FAIL repeat_frames: got %0d want %0d", win_q.size(), REAL_FRAMES); end
        checks++; if (cyc != REAL_FRAMES * (WIN + 1) + 1) begin errors++; $display("FAIL repeat_latency: got %0d want %0d", cyc, REAL_FRAMES * (WIN + 1) + 1); end
        Read = 1'b0;
        @(negedge HCLK);
        $display("repeat channel 3: result %h in %0d cycles", exp, cyc);
    endtask

    task automatic test_out_of_range();
        int cyc; bit to; logic [11:0] exp;
        win_q.delete();
        exp_q.push_back(12'h000);
        run_request(4'b1010, cyc, to);
        exp = exp_q.pop_front();
        checks++; if (to || cyc != 1) begin errors++; $display("FAIL oor_latency: got %0d want 1", cyc); end
        checks++; if (Resault !== exp) begin errors++; $display("FAIL oor_result: got %h want %h", Resault, exp); end
        Read = 1'b0;
        repeat (3) @(negedge HCLK);
        checks++; if (win_q.size() != 0 || low_cnt != 0) begin errors++; $display("FAIL oor_cs_activity: got %0d frames want 0", win_q.size()); end
        $display("out of range channel 1010: result %h in %0d cycles", exp, cyc);
    endtask

    task automatic test_reset_mid_frame();
        int cyc; bit to; logic [11:0] exp;
        @(negedge HCLK);
        Read = 1'b1;
        Channel_Select = 4'd5;
        repeat (20) @(negedge HCLK);
        checks++; if (ADC_CS_n !== 1'b0) begin errors++; $display("FAIL midrst_in_frame: cs_n got %b want 0", ADC_CS_n); end
        HRESET = 1'b1;
        Read = 1'b0;
        @(negedge HCLK);
        checks++; if (ADC_CS_n !== 1'b1 || ADC_SCLK !== 1'b1 || RDY_BSYn !== 1'b0) begin errors++; $display("FAIL midrst_outputs: cs_n=%b sclk=%b rdy=%b want 1 1 0", ADC_CS_n, ADC_SCLK, RDY_BSYn); end
        HRESET = 1'b0;
        repeat (2) @(negedge HCLK);
        win_q.delete(); din_q.delete();
        exp_q.push_back(adc_data[3]);
        run_request(4'd3, cyc, to);
        exp = exp_q.pop_front();
        checks++; if (to || Resault !== exp) begin errors++; $display("FAIL midrst_result: got %h want %h", Resault, exp); end
        checks++; if (win_q.size() != 1 + REAL_FRAMES) begin errors++; $display("FAIL midrst_frames: got %0d want %0d", win_q.size(), 1 + REAL_FRAMES); end
        Read = 1'b0;
        @(negedge HCLK);
        $display("reset mid-frame then channel 3: result %h, %0d frames", exp, win_q.size());
    endtask

    task automatic test_read_drop();
        int cyc; bit to; logic [11:0] exp;
        adc_data[3] = 12'h3C7;
        win_q.delete(); din_q.delete();
        exp_q.push_back(12'h3C7);
        @(negedge HCLK);
        Read = 1'b1;
        Channel_Select = 4'd3;
        cyc = 0;
        to = 1'b1;
        while (cyc < BUDGET) begin
            @(negedge HCLK);
            cyc++;
            if (cyc == 40) begin
                Read = 1'b0;
                Channel_Select = 4'd6;
            end
            if (RDY_BSYn === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        exp = exp_q.pop_front();
        checks++; if (to || Resault !== exp) begin errors++; $display("FAIL drop_result: got %h want %h", Resault, exp); end
        checks++; if (din_q.size() != REAL_FRAMES || (din_q.size() > 0 && din_q[0] !== {2'b00, 3'd3, 11'd0})) begin errors++; $display("FAIL drop_din: frames=%0d want %0d, channel 3 command", din_q.size(), REAL_FRAMES); end
        @(negedge HCLK);
        checks++; if (RDY_BSYn !== 1'b0) begin errors++; $display("FAIL drop_rdy_width: got %b want 0", RDY_BSYn); end
        repeat (20) @(negedge HCLK);
        checks++; if (win_q.size() != REAL_FRAMES || ADC_CS_n !== 1'b1) begin errors++; $display("FAIL drop_idle: frames=%0d cs_n=%b want %0d 1", win_q.size(), ADC_CS_n, REAL_FRAMES); end
        $display("read dropped mid-frame: result %h", exp);
    endtask

`ifdef ADC_SPI_AVG4_EN
    task automatic test_avg4();
        int cyc; bit to; logic [11:0] exp;
        win_q.delete();
        ovr_q = '{12'd0, 12'd100, 12'd101, 12'd102, 12'd103};
        exp_q.push_back(12'd102);
        run_request(4'd7, cyc, to);
        exp = exp_q.pop_front();
        checks++; if (to || Resault !== exp) begin errors++; $display("FAIL avg_result: got %0d want %0d", Resault, exp); end
        checks++; if (win_q.size() != 5) begin errors++; $display("FAIL avg_frames: got %0d want 5", win_q.size()); end
        Read = 1'b0;
        @(negedge HCLK);
        $display("avg4 channel 7: result %0d", exp);
    endtask
`endif

    initial begin
        for (int k = 0; k < 8; k++) adc_data[k] = 12'hFFF - 12'(k);
        test_reset();
        test_new_channel();
        test_repeat_channel();
        test_out_of_range();
        test_reset_mid_frame();
        test_read_drop();
`ifdef ADC_SPI_AVG4_EN
        test_avg4();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
